// File: rtl/adder_share_sequencer.sv
// adder_share_sequencer: round-robin front end that streams multi-word adds through one shared registered adder
module adder_share_sequencer #(
    parameter int WIDTH  = 8,
    parameter int NBYTES = 4,
    parameter int NREQ   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREQ-1:0]               req_valid,
    output logic [NREQ-1:0]               req_ready,
    input  logic [NREQ*NBYTES*WIDTH-1:0]  req_a,
    input  logic [NREQ*NBYTES*WIDTH-1:0]  req_b,
    input  logic [NREQ-1:0]               req_cin,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [$clog2(NREQ)-1:0]       rsp_id,
    output logic [NBYTES*WIDTH-1:0]       rsp_sum,
    output logic                          rsp_cout,
    output logic                          busy,
    output logic [WIDTH-1:0]              add_a,
    output logic [WIDTH-1:0]              add_b,
    output logic                          add_cin,
    input  logic [WIDTH-1:0]              add_sum,
    input  logic                          add_cout
);
    localparam int OW  = NBYTES * WIDTH;
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(NBYTES + 1);
    localparam int WW  = NBYTES > 1 ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                        state, state_nx;
    logic [IDW-1:0]                ptr, gnt, id_r, scan;
    logic                          gnt_ok, acc, last, drive;
    logic [CW-1:0]                 cnt;
    logic [WW-1:0]                 wi, wm1;
    logic [NREQ-1:0][OW-1:0]       ra, rb;
    logic [NBYTES-1:0][WIDTH-1:0]  a_r, b_r, sum_r;
    logic                          cin_r, cout_r;

    assign ra    = req_a;
    assign rb    = req_b;
    assign acc   = state == IDLE && gnt_ok && !rst;
    assign last  = cnt == CW'(NBYTES);
    assign drive = state == RUN && !last;
    assign wi    = cnt[WW-1:0];
    assign wm1   = cnt[WW-1:0] - WW'(1);

    assign rsp_valid = state == DONE;
    assign busy      = state != IDLE;
    assign rsp_id    = id_r;
    assign rsp_sum   = sum_r;
    assign rsp_cout  = cout_r;
    assign add_a     = drive ? a_r[wi] : '0;
    assign add_b     = drive ? b_r[wi] : '0;
    assign add_cin   = drive && (cnt == '0 ? cin_r : add_cout);

    // first pending requester at or after the pointer, wrapping round
    always_comb begin
        gnt    = '0;
        gnt_ok = 1'b0;
        scan   = ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_ok && req_valid[scan]) begin
                gnt    = scan;
                gnt_ok = 1'b1;
            end
            scan = scan == IDW'(NREQ - 1) ? '0 : scan + IDW'(1);
        end
    end

    // accept strobe only for the granted requester, only while idle
    always_comb begin
        req_ready = '0;
        if (acc) req_ready[gnt] = 1'b1;
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next-state: accept -> word sequencing -> hold result until consumed
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = gnt_ok ? RUN : IDLE;
            RUN:     state_nx = last ? DONE : RUN;
            DONE:    state_nx = rsp_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    // operand latch, arbitration pointer, word counter and result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr    <= '0;
            cnt    <= '0;
            a_r    <= '0;
            b_r    <= '0;
            cin_r  <= 1'b0;
            id_r   <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
        end else begin
            if (acc) begin
                a_r   <= ra[gnt];
                b_r   <= rb[gnt];
                cin_r <= req_cin[gnt];
                id_r  <= gnt;
                ptr   <= gnt == IDW'(NREQ - 1) ? '0 : gnt + IDW'(1);
                cnt   <= '0;
            end
            if (state == RUN) begin
                if (!last) cnt <= cnt + CW'(1);
                if (cnt != '0) sum_r[wm1] <= add_sum;
                if (last) cout_r <= add_cout;
            end
        end
    end
endmodule

// File: tb/tb_adder_share_sequencer.sv
// tb_adder_share_sequencer: table vectors plus multi-cycle corner sequences, checked through a response scoreboard
module tb_adder_share_sequencer;
    localparam int WIDTH = 8, NBYTES = 4, NREQ = 2, OW = NBYTES * WIDTH;

    logic                 clk = 1'b0, rst = 1'b1;
    logic [NREQ-1:0]      req_valid, req_ready, req_cin;
    logic [NREQ*OW-1:0]   req_a, req_b;
    logic                 rsp_valid, rsp_ready, rsp_cout, busy, add_cin, add_cout;
    logic [0:0]           rsp_id;
    logic [OW-1:0]        rsp_sum;
    logic [WIDTH-1:0]     add_a, add_b, add_sum;

    typedef struct {int id; logic [OW-1:0] a; logic [OW-1:0] b; logic cin; logic [OW-1:0] s; logic co;} vec_t;
    typedef struct {int id; logic [OW-1:0] s; logic co;} exp_t;

    exp_t sb[$];
    int   acc_ids[$], acc_cycs[$];
    int   n_chk = 0, n_fail = 0, cyc = 0, acc_cyc = 0, hs_cyc = 0, n_rsp = 0;
    logic prev_rv = 1'b0;

    adder_share_sequencer #(.WIDTH(WIDTH), .NBYTES(NBYTES), .NREQ(NREQ)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .req_cin(req_cin), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
        .rsp_cout(rsp_cout), .busy(busy), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout)
    );

    always #5 clk = ~clk;

    // shared adder: registered, one cycle of latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) {add_cout, add_sum} <= '0;
        else     {add_cout, add_sum} <= 9'(add_a) + 9'(add_b) + 9'(add_cin);
    end

    function automatic logic [OW:0] model(input logic [OW-1:0] a, input logic [OW-1:0] b, input logic c);
        return 33'(a) + 33'(b) + 33'(c);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // protocol monitor and scoreboard, sampled on the falling edge
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            sb.delete();
            prev_rv = 1'b0;
        end else begin
            if (busy) chk("ready_while_busy", 64'(req_ready), 64'(0));
            if (|req_ready) begin
                chk("ready_onehot", 64'($onehot(req_ready)), 64'(1));
                acc_cyc = cyc;
                acc_ids.push_back(req_ready[1] ? 1 : 0);
                acc_cycs.push_back(cyc);
            end
            if (rsp_valid && !prev_rv) chk("latency", 64'(cyc - acc_cyc), 64'(6));
            if (rsp_valid && rsp_ready) begin
                hs_cyc = cyc;
                n_rsp++;
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got id %0d sum %0h with nothing expected", rsp_id, rsp_sum);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_id", 64'(rsp_id), 64'(e.id));
                    chk("rsp_sum", 64'(rsp_sum), 64'(e.s));
                    chk("rsp_cout", 64'(rsp_cout), 64'(e.co));
                end
            end
            prev_rv = rsp_valid;
        end
    end

    task automatic drive(input int id, input logic [OW-1:0] a, input logic [OW-1:0] b, input logic c, input logic [OW:0] x);
        exp_t e;
        req_a[id*OW +: OW] = a;
        req_b[id*OW +: OW] = b;
        req_cin[id]        = c;
        req_valid[id]      = 1'b1;
        e.id = id;
        {e.co, e.s} = x;
        sb.push_back(e);
    endtask

    task automatic wait_acc(input int id);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[id] && n < 30);
        chk("accept_seen", 64'(req_ready[id]), 64'(1));
        @(posedge clk);
        #1 req_valid[id] = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        int n = 0;
        while (n_rsp < target && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_count", 64'(n_rsp), 64'(target));
    endtask

    initial begin
        vec_t        tv[6];
        int          tgt, n;
        logic [OW:0] x0, x1, xb;
        tv[0] = '{0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1};
        tv[1] = '{1, 32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0};
        tv[2] = '{0, 32'h00FF_FFFF, 32'h0000_0000, 1'b1, 32'h0100_0000, 1'b0};
        tv[3] = '{1, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0001, 1'b1};
        tv[4] = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
        tv[5] = '{1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0};
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_outputs", 64'({rsp_valid, rsp_id, rsp_sum, rsp_cout, busy, req_ready, add_a, add_b, add_cin}), 64'(0));
        req_valid = 2'b11;
        @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'(0));
        req_valid = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1 tgt = n_rsp + 1;
            drive(tv[i].id, tv[i].a, tv[i].b, tv[i].cin, {tv[i].co, tv[i].s});
            wait_acc(tv[i].id);
            wait_rsp(tgt);
        end
        // carry rippling through every word
        @(posedge clk);
        #1 tgt = n_rsp + 1;
        drive(0, 32'h00FF_FFFF, 32'h0, 1'b1, model(32'h00FF_FFFF, 32'h0, 1'b1));
        wait_acc(0);
        @(negedge clk);
        chk("carry_cin_w0", 64'(add_cin), 64'(1));
        chk("carry_a_w0", 64'(add_a), 64'(8'hFF));
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            chk("carry_cin_chain", 64'(add_cin), 64'(1));
        end
        wait_rsp(tgt);
        // back-pressure in DONE with a competing request waiting
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        tgt = n_rsp + 2;
        xb = model(32'hDEAD_BEEF, 32'h0102_0304, 1'b0);
        drive(0, 32'hDEAD_BEEF, 32'h0102_0304, 1'b0, xb);
        wait_acc(0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 drive(1, 32'h0000_0005, 32'h0000_0007, 1'b1, model(32'h5, 32'h7, 1'b1));
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_valid", 64'(rsp_valid), 64'(1));
            chk("bp_hold", 64'({rsp_cout, rsp_sum, rsp_id}), 64'({xb, 1'b0}));
            chk("bp_no_accept", 64'(req_ready), 64'(0));
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_acc(1);
        chk("accept_after_handshake", 64'(acc_cyc - hs_cyc), 64'(1));
        wait_rsp(tgt);
        // both requesters pending from reset: strict alternation
        @(posedge clk);
        #1 rst = 1'b1;
        req_valid = '0;
        @(negedge clk);
        req_a   = {32'h0000_0002, 32'h0000_0001};
        req_b   = {32'h0000_0020, 32'h0000_0010};
        req_cin = 2'b10;
        req_valid = 2'b11;
        @(posedge clk);
        #1 rst = 1'b0;
        x0 = model(32'h1, 32'h10, 1'b0);
        x1 = model(32'h2, 32'h20, 1'b1);
        sb.push_back('{0, x0[OW-1:0], x0[OW]});
        sb.push_back('{1, x1[OW-1:0], x1[OW]});
        sb.push_back('{0, x0[OW-1:0], x0[OW]});
        sb.push_back('{1, x1[OW-1:0], x1[OW]});
        acc_ids.delete();
        acc_cycs.delete();
        tgt = n_rsp + 4;
        n = 0;
        while (acc_ids.size() < 4 && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 req_valid = '0;
        wait_rsp(tgt);
        chk("rr_accept_count", 64'(acc_ids.size()), 64'(4));
        if (acc_ids.size() >= 4)
            for (int k = 0; k < 4; k++) begin
                chk("rr_order", 64'(acc_ids[k]), 64'(k % 2));
                if (k > 0) chk("rr_interval", 64'(acc_cycs[k] - acc_cycs[k-1]), 64'(7));
            end
        // reset in the middle of a run
        @(posedge clk);
        #1 drive(0, 32'hCAFE_F00D, 32'h1357_9BDF, 1'b1, model(32'hCAFE_F00D, 32'h1357_9BDF, 1'b1));
        wait_acc(0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst = 1'b1;
        tgt = n_rsp;
        @(negedge clk);
        chk("midrst_outputs", 64'({rsp_valid, rsp_id, rsp_sum, rsp_cout, busy, req_ready, add_a, add_b, add_cin}), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        drive(1, 32'h0000_00F0, 32'h0000_0010, 1'b0, model(32'hF0, 32'h10, 1'b0));
        wait_acc(1);
        wait_rsp(tgt + 1);
        chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
        $fatal(1);
    end
endmodule
